// File: rtl/rw_stage_pkg.sv
// Shared types and constants for the register-write stage and its GPR file.
package rw_stage_pkg;

  localparam int XLEN = 32;
  localparam int NREG = 16;
  localparam int AW   = $clog2(NREG);
  localparam int NRD  = 2;

  localparam logic [AW-1:0]   RA_IDX = AW'(15);
  localparam logic [XLEN-1:0] PC_INC = XLEN'(4);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] ld_result;
    logic            is_wb;
    logic            is_ld;
    logic            is_call;
  } ma_rw_t;

  function automatic logic [AW-1:0] rd_of(input logic [XLEN-1:0] instr);
    return instr[25:22];
  endfunction

endpackage

// File: rtl/rw_stage_gpr_file.sv
// NREG x XLEN register file: one write port, NRD combinational read ports
// that see the write being committed this cycle (write-first).
module gpr_file
  import rw_stage_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      we,
  input  logic [AW-1:0]             waddr,
  input  logic [XLEN-1:0]           wdata,
  input  logic [NRD-1:0][AW-1:0]    raddr,
  output logic [NRD-1:0][XLEN-1:0]  rdata
);

  logic [NREG-1:0][XLEN-1:0] regs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     regs        <= '0;
    else if (we) regs[waddr] <= wdata;
  end

  genvar p;
  generate
    for (p = 0; p < NRD; p++) begin : g_rd
      assign rdata[p] = (we && raddr[p] == waddr) ? wdata : regs[raddr[p]];
    end
  endgenerate

endmodule

// File: rtl/rw_stage.sv
// Register-write stage: latches the MA payload, selects write-back value and
// destination, commits into the owned GPR file and counts retirements.
module rw_stage
  import rw_stage_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            ma_valid,
  input  logic [XLEN-1:0] ma_pc,
  input  logic [XLEN-1:0] ma_instr,
  input  logic [XLEN-1:0] ma_alu_result,
  input  logic [XLEN-1:0] ma_ld_result,
  input  logic            ma_is_wb,
  input  logic            ma_is_ld,
  input  logic            ma_is_call,
  input  logic [AW-1:0]   rd_addr1,
  output logic [XLEN-1:0] rd_data1,
  input  logic [AW-1:0]   rd_addr2,
  output logic [XLEN-1:0] rd_data2,
  output logic            wb_valid,
  output logic [AW-1:0]   wb_addr,
  output logic [XLEN-1:0] wb_data,
  output logic [31:0]     retire_cnt
);

  ma_rw_t rw_q;
  logic   rw_valid_q;

  // Payload only loads on valid; the valid bit itself follows ma_valid every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rw_q       <= '0;
      rw_valid_q <= 1'b0;
    end else begin
      rw_valid_q <= ma_valid;
      if (ma_valid)
        rw_q <= '{pc: ma_pc, instr: ma_instr, alu_result: ma_alu_result,
                  ld_result: ma_ld_result, is_wb: ma_is_wb, is_ld: ma_is_ld,
                  is_call: ma_is_call};
    end
  end

  always_comb begin
    wb_valid = rw_valid_q & (rw_q.is_wb | rw_q.is_call);
    wb_addr  = rw_q.is_call ? RA_IDX : rd_of(rw_q.instr);
    wb_data  = rw_q.is_call ? rw_q.pc + PC_INC
             : rw_q.is_ld   ? rw_q.ld_result
             :                rw_q.alu_result;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             retire_cnt <= '0;
    else if (rw_valid_q) retire_cnt <= retire_cnt + 32'd1;
  end

  logic [NRD-1:0][AW-1:0]   raddr;
  logic [NRD-1:0][XLEN-1:0] rdata;

  assign raddr    = {rd_addr2, rd_addr1};
  assign rd_data1 = rdata[0];
  assign rd_data2 = rdata[1];

  gpr_file u_gpr (
    .clk   (clk),
    .rst   (rst),
    .we    (wb_valid),
    .waddr (wb_addr),
    .wdata (wb_data),
    .raddr (raddr),
    .rdata (rdata)
  );

  // Only rd is decoded from the instruction word here.
  logic rw_unused;
  assign rw_unused = ^{rw_q.instr[31:26], rw_q.instr[21:0]};

endmodule

// File: tb/tb_rw_stage.sv
// Directed and random stimulus for rw_stage against an architectural model of
// the GPR file with one in-flight write and a retirement counter.
module tb_rw_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ma_valid;
  logic [31:0] ma_pc, ma_instr, ma_alu_result, ma_ld_result;
  logic        ma_is_wb, ma_is_ld, ma_is_call;
  logic [3:0]  rd_addr1, rd_addr2;
  logic [31:0] rd_data1, rd_data2;
  logic        wb_valid;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;
  logic [31:0] retire_cnt;

  rw_stage dut (
    .clk(clk), .rst(rst),
    .ma_valid(ma_valid), .ma_pc(ma_pc), .ma_instr(ma_instr),
    .ma_alu_result(ma_alu_result), .ma_ld_result(ma_ld_result),
    .ma_is_wb(ma_is_wb), .ma_is_ld(ma_is_ld), .ma_is_call(ma_is_call),
    .rd_addr1(rd_addr1), .rd_data1(rd_data1),
    .rd_addr2(rd_addr2), .rd_data2(rd_data2),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  // Model: architectural registers, the instruction sitting in RW, retired count.
  logic [31:0] m_gpr [16];
  logic        m_pv, m_pwe;
  logic [3:0]  m_pa;
  logic [31:0] m_pd;
  logic [31:0] m_cnt;
  int          total = 0, passes = 0;
  logic [31:0] prev_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [31:0] m_read(input logic [3:0] a);
    return (m_pv && m_pwe && a == m_pa) ? m_pd : m_gpr[a];
  endfunction

  task automatic m_clear();
    foreach (m_gpr[i]) m_gpr[i] = '0;
    m_pv = 0; m_pwe = 0; m_pa = '0; m_pd = '0; m_cnt = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    if (m_pv && m_pwe) m_gpr[m_pa] = m_pd;
    if (m_pv) m_cnt = m_cnt + 1;
    m_pv = ma_valid;
    if (ma_valid) begin
      m_pwe = ma_is_wb | ma_is_call;
      m_pa  = ma_is_call ? 4'd15 : ma_instr[25:22];
      m_pd  = ma_is_call ? ma_pc + 32'd4 : (ma_is_ld ? ma_ld_result : ma_alu_result);
    end
    #1;
  endtask

  task automatic check_all(input string tag);
    #1;
    chk({tag, ".wb_valid"}, {31'd0, wb_valid}, {31'd0, m_pv && m_pwe});
    if (m_pv && m_pwe) begin
      chk({tag, ".wb_addr"}, {28'd0, wb_addr}, {28'd0, m_pa});
      chk({tag, ".wb_data"}, wb_data, m_pd);
    end
    chk({tag, ".rd1"}, rd_data1, m_read(rd_addr1));
    chk({tag, ".rd2"}, rd_data2, m_read(rd_addr2));
    chk({tag, ".retire"}, retire_cnt, m_cnt);
  endtask

  function automatic logic [31:0] mk_instr(input logic [3:0] rd);
    logic [31:0] w;
    w = $urandom;
    w[25:22] = rd;
    return w;
  endfunction

  task automatic op(input logic v, input logic [31:0] pc, input logic [3:0] rd,
                    input logic [31:0] alu, input logic [31:0] ld,
                    input logic wb, input logic isld, input logic call);
    ma_valid = v; ma_pc = pc; ma_instr = mk_instr(rd);
    ma_alu_result = alu; ma_ld_result = ld;
    ma_is_wb = wb; ma_is_ld = isld; ma_is_call = call;
  endtask

  task automatic idle();
    op(1'b0, $urandom, 4'($urandom), $urandom, $urandom, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    rd_addr1 = 4'd3; rd_addr2 = 4'd15;
    m_clear();
    #2;
    chk("reset.rd1", rd_data1, 32'h0);
    chk("reset.rd2", rd_data2, 32'h0);
    chk("reset.retire", retire_cnt, 32'h0);
    chk("reset.wb_valid", {31'd0, wb_valid}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // ALU write with bypass, then committed.
    op(1'b1, 32'h100, 4'd5, 32'hDEADBEEF, 32'h0, 1'b1, 1'b0, 1'b0);
    rd_addr1 = 4'd5; rd_addr2 = 4'd0;
    tick();
    idle();
    check_all("alu.byp");
    chk("alu.byp_lit", rd_data1, 32'hDEADBEEF);
    tick();
    check_all("alu.gpr");
    chk("alu.gpr_lit", rd_data1, 32'hDEADBEEF);

    // Load, then call whose return address wraps.
    op(1'b1, 32'h104, 4'd2, 32'h5A5A5A5A, 32'h12345678, 1'b1, 1'b1, 1'b0);
    tick();
    op(1'b1, 32'hFFFFFFFC, 4'd3, 32'h77, 32'h88, 1'b1, 1'b1, 1'b1);
    rd_addr1 = 4'd2; rd_addr2 = 4'd15;
    check_all("ld.byp");
    tick();
    idle();
    check_all("call.byp");
    chk("ld.gpr_lit", rd_data1, 32'h12345678);
    chk("call.byp_lit", rd_data2, 32'h0);
    chk("call.addr_lit", {28'd0, wb_addr}, 32'd15);
    tick();
    check_all("call.gpr");

    // Non-writing instruction still retires.
    op(1'b1, 32'h200, 4'd7, 32'hAAAA5555, 32'h0, 1'b0, 1'b0, 1'b0);
    rd_addr1 = 4'd7;
    prev_cnt = retire_cnt;
    tick();
    idle();
    check_all("nowb.e1");
    tick();
    check_all("nowb.e2");
    chk("nowb.r7", rd_data1, 32'h0);
    chk("nowb.retire_lit", retire_cnt, prev_cnt + 32'd1);

    // Back-to-back writes to r4 on both read ports.
    rd_addr1 = 4'd4; rd_addr2 = 4'd4;
    op(1'b1, 32'h300, 4'd4, 32'h11, 32'h0, 1'b1, 1'b0, 1'b0);
    tick();
    op(1'b1, 32'h304, 4'd4, 32'h22, 32'h0, 1'b1, 1'b0, 1'b0);
    check_all("b2b.first");
    chk("b2b.first_lit", rd_data1, 32'h11);
    tick();
    idle();
    check_all("b2b.second");
    chk("b2b.second_lit", rd_data2, 32'h22);
    tick();
    check_all("b2b.final");
    chk("b2b.final_lit", rd_data1, 32'h22);

    // Reset lands between capture and commit.
    op(1'b1, 32'h400, 4'd6, 32'h99, 32'h0, 1'b1, 1'b0, 1'b0);
    rd_addr1 = 4'd6; rd_addr2 = 4'd4;
    tick();
    idle();
    rst = 1'b1;
    m_clear();
    #2;
    check_all("rstmid.in");
    rst = 1'b0;
    tick();
    check_all("rstmid.after");
    chk("rstmid.r6", rd_data1, 32'h0);
    chk("rstmid.retire", retire_cnt, 32'h0);

    // Random traffic with overlapping flags and arbitrary read addresses.
    for (int i = 0; i < 300; i++) begin
      op(($urandom_range(0, 3) != 0), $urandom, 4'($urandom), $urandom, $urandom,
         1'($urandom), 1'($urandom), ($urandom_range(0, 5) == 0));
      rd_addr1 = 4'($urandom);
      rd_addr2 = ($urandom_range(0, 3) == 0) ? rd_addr1 : 4'($urandom);
      tick();
      check_all("rand");
    end
    idle();
    tick();
    for (int a = 0; a < 16; a++) begin
      rd_addr1 = 4'(a); rd_addr2 = 4'(15 - a);
      check_all("sweep");
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
